// File: rtl/audio_level_meter_pkg.sv
// Shared definitions for the audio level meter: source-select encodings,
// peak-hold state type and the magnitude / bar-threshold helpers.
package audio_meter_pkg;

    localparam logic [1:0] MODE_LEFT  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_MAX   = 2'b10;

    typedef enum logic {
        HOLD_NONE   = 1'b0,
        HOLD_ACTIVE = 1'b1
    } hold_state_e;

    // |x| of a sign-extended width-bit sample; the most negative code clips
    // to the largest positive magnitude so the result fits in width-1 bits.
    function automatic logic [63:0] abs_sat(input logic [63:0] x_sext, input int unsigned width);
        logic [63:0] mag;
        logic [63:0] lim;
        lim = (64'd1 << (width - 1)) - 64'd1;
        if (x_sext[63]) begin
            mag = ~x_sext + 64'd1;
        end else begin
            mag = x_sext;
        end
        if (mag > lim) begin
            mag = lim;
        end
        return mag;
    endfunction

    function automatic logic [63:0] bar_threshold(input int unsigned data_w,
                                                  input int unsigned num_bars,
                                                  input int unsigned k);
        return 64'd1 << (data_w - 1 - num_bars + k);
    endfunction

    // Index of the highest set bit among the low n bits, -1 when none are set.
    function automatic int highest_set(input logic [63:0] v, input int n);
        int idx;
        idx = -1;
        for (int i = 0; i < n; i++) begin
            if (v[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/audio_level_meter_if.sv
// Codec sample handshake: the codec offers a stereo pair with read_ready and
// the consumer pops it by raising read in the same cycle.
interface audio_level_meter_if #(
    parameter int DATA_W = 24
) ();
    logic              read_ready;
    logic [DATA_W-1:0] readdata_left;
    logic [DATA_W-1:0] readdata_right;
    logic              read;

    modport master (
        output read_ready,
        output readdata_left,
        output readdata_right,
        input  read
    );

    modport slave (
        input  read_ready,
        input  readdata_left,
        input  readdata_right,
        output read
    );
endinterface

// File: rtl/audio_level_meter_peak_tracker.sv
// One channel's frame peak: saturating magnitude, running max over the frame,
// published on tick together with any sample popped in that same cycle.
module peak_tracker
    import audio_meter_pkg::*;
#(
    parameter int DATA_W = 24
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    input  logic              tick,
    output logic [DATA_W-2:0] frame_peak,
    output logic [DATA_W-2:0] peak
);
    localparam int PEAK_W = DATA_W - 1;

    logic [PEAK_W-1:0] mag;
    logic [PEAK_W-1:0] acc_reg;
    logic [PEAK_W-1:0] peak_reg;

    assign mag = PEAK_W'(abs_sat(64'(signed'(sample)), DATA_W));

    // Value the frame would close with right now, including a coincident sample.
    always_comb begin
        frame_peak = acc_reg;
        if (sample_valid && (mag > acc_reg)) begin
            frame_peak = mag;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            acc_reg  <= '0;
            peak_reg <= '0;
        end else if (tick) begin
            peak_reg <= frame_peak;
            acc_reg  <= '0;
        end else if (sample_valid) begin
            acc_reg <= frame_peak;
        end
    end

    assign peak = peak_reg;

endmodule

// File: rtl/audio_level_meter.sv
// Stereo level meter: per-channel frame peaks, a 6 dB/segment thermometer of
// the selected source with decaying peak-hold marker, and a loudness flag.
module audio_level_meter
    import audio_meter_pkg::*;
#(
    parameter int              DATA_W      = 24,
    parameter int              NUM_BARS    = 10,
    parameter int              HOLD_FRAMES = 30,
    parameter logic [DATA_W-1:0] LOUD_THRESH = 24'h100000
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                enable,
    input  logic [1:0]          mode,
    input  logic                tick,
    audio_level_meter_if.slave  codec,
    output logic [DATA_W-2:0]   peak_left,
    output logic [DATA_W-2:0]   peak_right,
    output logic [NUM_BARS-1:0] bars,
    output logic [NUM_BARS-1:0] hold_bar,
    output logic                loud,
    output logic                frame_done
);
    localparam int PEAK_W = DATA_W - 1;
    localparam int IDX_W  = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
    localparam int CNT_W  = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

    logic [PEAK_W-1:0]   frame_peak_l;
    logic [PEAK_W-1:0]   frame_peak_r;
    logic [PEAK_W-1:0]   sel_peak;
    logic [NUM_BARS-1:0] bars_next;
    logic                loud_next;
    int                  top_idx;
    logic                hold_take;

    logic [NUM_BARS-1:0] bars_reg;
    logic [NUM_BARS-1:0] hold_bar_reg;
    logic                loud_reg;
    logic                frame_done_reg;
    hold_state_e         hold_state_reg;
    logic [IDX_W-1:0]    hold_idx_reg;
    logic [CNT_W-1:0]    hold_cnt_reg;

    assign codec.read = codec.read_ready & enable & ~reset;

    peak_tracker #(.DATA_W(DATA_W)) u_peak_left (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .sample_valid (codec.read),
        .sample       (codec.readdata_left),
        .tick         (tick),
        .frame_peak   (frame_peak_l),
        .peak         (peak_left)
    );

    peak_tracker #(.DATA_W(DATA_W)) u_peak_right (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .sample_valid (codec.read),
        .sample       (codec.readdata_right),
        .tick         (tick),
        .frame_peak   (frame_peak_r),
        .peak         (peak_right)
    );

    // Source select is only consumed at tick, so a mid-frame change waits for the frame end.
    always_comb begin
        sel_peak = frame_peak_l;
        case (mode)
            MODE_LEFT:  sel_peak = frame_peak_l;
            MODE_RIGHT: sel_peak = frame_peak_r;
            default:    sel_peak = (frame_peak_l > frame_peak_r) ? frame_peak_l : frame_peak_r;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BARS; gi++) begin : g_bar
            assign bars_next[gi] = 64'(sel_peak) >= bar_threshold(DATA_W, NUM_BARS, gi);
        end
    endgenerate

    assign loud_next = {1'b0, sel_peak} >= LOUD_THRESH;
    assign top_idx   = highest_set(64'(bars_next), NUM_BARS);
    assign hold_take = (top_idx >= 0) &&
                       ((hold_state_reg == HOLD_NONE) || (top_idx >= int'(hold_idx_reg)));

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            bars_reg       <= '0;
            hold_bar_reg   <= '0;
            loud_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
            hold_state_reg <= HOLD_NONE;
            hold_idx_reg   <= '0;
            hold_cnt_reg   <= '0;
        end else begin
            frame_done_reg <= tick;
            if (tick) begin
                bars_reg <= bars_next;
                loud_reg <= loud_next;
                if (hold_take) begin
                    hold_state_reg <= HOLD_ACTIVE;
                    hold_idx_reg   <= IDX_W'(top_idx);
                    hold_cnt_reg   <= CNT_W'(HOLD_FRAMES);
                    hold_bar_reg   <= NUM_BARS'(1) << top_idx;
                end else if (hold_cnt_reg != '0) begin
                    hold_cnt_reg <= hold_cnt_reg - 1'b1;
                end else if (hold_state_reg == HOLD_ACTIVE) begin
                    // Marker walks down one segment per frame and falls off below bit 0.
                    hold_bar_reg <= hold_bar_reg >> 1;
                    if (hold_idx_reg == '0) begin
                        hold_state_reg <= HOLD_NONE;
                    end else begin
                        hold_idx_reg <= hold_idx_reg - 1'b1;
                    end
                end
            end
        end
    end

    assign bars       = bars_reg;
    assign hold_bar   = hold_bar_reg;
    assign loud       = loud_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_audio_level_meter.sv
// Scoreboard bench for audio_level_meter: stimulus pushes hand-computed frame
// results, a negedge monitor pops and compares on every frame_done pulse.
module tb_audio_level_meter;

    localparam int DATA_W   = 24;
    localparam int NUM_BARS = 10;

    typedef struct packed {
        logic [7:0]  tag;
        logic [22:0] pl;
        logic [22:0] pr;
        logic [9:0]  bars;
        logic [9:0]  hold;
        logic        loud;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [1:0]  mode;
    logic        tick;
    logic [22:0] peak_left;
    logic [22:0] peak_right;
    logic [9:0]  bars;
    logic [9:0]  hold_bar;
    logic        loud;
    logic        frame_done;

    exp_t exp_q[$];
    int   check_count = 0;
    int   pass_count  = 0;
    int   read_count  = 0;
    int   tag_n       = 0;

    always #5 clk = ~clk;

    audio_level_meter_if #(.DATA_W(DATA_W)) codec ();

    audio_level_meter #(
        .DATA_W      (DATA_W),
        .NUM_BARS    (NUM_BARS),
        .HOLD_FRAMES (3),
        .LOUD_THRESH (24'h100000)
    ) dut (
        .CLOCK_50   (clk),
        .reset      (reset),
        .enable     (enable),
        .mode       (mode),
        .tick       (tick),
        .codec      (codec),
        .peak_left  (peak_left),
        .peak_right (peak_right),
        .bars       (bars),
        .hold_bar   (hold_bar),
        .loud       (loud),
        .frame_done (frame_done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        check_count++;
        if (act === exp) begin
            pass_count++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: counts pops and scores each published frame.
    always @(negedge clk) begin
        exp_t e;
        if (codec.read === 1'b1) read_count++;
        if (frame_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("frame_done_unexpected", 64'(frame_done), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("f%0d_peak_left", e.tag), 64'(peak_left), 64'(e.pl));
                check($sformatf("f%0d_peak_right", e.tag), 64'(peak_right), 64'(e.pr));
                check($sformatf("f%0d_bars", e.tag), 64'(bars), 64'(e.bars));
                check($sformatf("f%0d_hold_bar", e.tag), 64'(hold_bar), 64'(e.hold));
                check($sformatf("f%0d_loud", e.tag), 64'(loud), 64'(e.loud));
                $display("frame %0d: peak_left=%06h peak_right=%06h bars=%03h hold_bar=%03h loud=%0d",
                         e.tag, peak_left, peak_right, bars, hold_bar, loud);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick  = 1'b0;
        codec.read_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic sample(input logic [23:0] l, input logic [23:0] r);
        codec.read_ready     = 1'b1;
        codec.readdata_left  = l;
        codec.readdata_right = r;
        step();
        codec.read_ready = 1'b0;
    endtask

    task automatic push_exp(input logic [22:0] pl, input logic [22:0] pr,
                            input logic [9:0] b, input logic [9:0] h, input logic ld);
        exp_t e;
        e.tag  = 8'(tag_n);
        e.pl   = pl;
        e.pr   = pr;
        e.bars = b;
        e.hold = h;
        e.loud = ld;
        exp_q.push_back(e);
        tag_n++;
    endtask

    task automatic frame(input logic [22:0] pl, input logic [22:0] pr,
                         input logic [9:0] b, input logic [9:0] h, input logic ld);
        push_exp(pl, pr, b, h, ld);
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] seq [5];
        logic [9:0]  h;
        int          rc0;

        reset = 1'b1;
        enable = 1'b1;
        mode = 2'b00;
        tick = 1'b0;
        codec.read_ready = 1'b0;
        codec.readdata_left = '0;
        codec.readdata_right = '0;
        step();
        step();
        step();
        check("rst_peak_left", 64'(peak_left), 64'd0);
        check("rst_peak_right", 64'(peak_right), 64'd0);
        check("rst_bars", 64'(bars), 64'd0);
        check("rst_hold_bar", 64'(hold_bar), 64'd0);
        check("rst_loud", 64'(loud), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        codec.read_ready = 1'b1;
        #1;
        check("rst_read_gated", 64'(codec.read), 64'd0);
        codec.read_ready = 1'b0;
        reset = 1'b0;
        step();

        // Full-scale frame, then reset arrives with a pending sample and a tick.
        sample(24'h7FFFFF, 24'h000000);
        frame(23'h7FFFFF, 23'h0, 10'h3FF, 10'h200, 1'b1);
        sample(24'h001000, 24'h000000);
        reset = 1'b1;
        tick = 1'b1;
        codec.read_ready = 1'b1;
        codec.readdata_left = 24'h7FFFFF;
        #1;
        check("rst_tick_read_gated", 64'(codec.read), 64'd0);
        step();
        reset = 1'b0;
        tick = 1'b0;
        codec.read_ready = 1'b0;
        check("rst_mid_peak_left", 64'(peak_left), 64'd0);
        check("rst_mid_bars", 64'(bars), 64'd0);
        check("rst_mid_hold_bar", 64'(hold_bar), 64'd0);
        check("rst_mid_loud", 64'(loud), 64'd0);
        step();
        frame(23'h0, 23'h0, 10'h000, 10'h000, 1'b0);

        // Left source, quiet / full negative / small negative samples.
        do_reset();
        mode = 2'b00;
        sample(24'h002000, 24'h000000);
        frame(23'h002000, 23'h0, 10'h001, 10'h001, 1'b0);
        sample(24'h800000, 24'h000000);
        frame(23'h7FFFFF, 23'h0, 10'h3FF, 10'h200, 1'b1);
        sample(24'hFFC000, 24'h000000);
        frame(23'h004000, 23'h0, 10'h003, 10'h200, 1'b0);

        // Source select: max, left, right (changed mid-frame), max via 11.
        do_reset();
        mode = 2'b10;
        sample(24'h000100, 24'h200000);
        frame(23'h000100, 23'h200000, 10'h1FF, 10'h100, 1'b1);
        mode = 2'b00;
        sample(24'h000100, 24'h200000);
        frame(23'h000100, 23'h200000, 10'h000, 10'h100, 1'b0);
        sample(24'h7FFFFF, 24'h002000);
        mode = 2'b01;
        step();
        frame(23'h7FFFFF, 23'h002000, 10'h001, 10'h100, 1'b0);
        mode = 2'b11;
        sample(24'h000100, 24'hC00000);
        frame(23'h000100, 23'h400000, 10'h3FF, 10'h200, 1'b1);

        // Peak hold: 3 frames of hold after the publish, then one segment per frame.
        do_reset();
        mode = 2'b00;
        sample(24'h7FFFFF, 24'h000000);
        frame(23'h7FFFFF, 23'h0, 10'h3FF, 10'h200, 1'b1);
        for (int i = 0; i < 14; i++) begin
            h = (i < 3) ? 10'h200 : 10'(10'h200 >> (i - 2));
            frame(23'h0, 23'h0, 10'h000, h, 1'b0);
        end

        // Back-to-back reads with a tick on the third; sample there closes the frame.
        do_reset();
        mode = 2'b00;
        seq[0] = 24'h001000;
        seq[1] = 24'h000800;
        seq[2] = 24'h400000;
        seq[3] = 24'h002000;
        seq[4] = 24'h000100;
        rc0 = read_count;
        codec.readdata_right = 24'h000000;
        for (int i = 0; i < 5; i++) begin
            codec.read_ready = 1'b1;
            codec.readdata_left = seq[i];
            if (i == 2) begin
                push_exp(23'h400000, 23'h0, 10'h3FF, 10'h200, 1'b1);
                tick = 1'b1;
            end
            step();
            tick = 1'b0;
        end
        codec.read_ready = 1'b0;
        step();
        check("b2b_read_pulses", 64'(read_count - rc0), 64'd5);
        frame(23'h002000, 23'h0, 10'h001, 10'h200, 1'b0);

        // Disabled: no pops, accumulation frozen, tick still publishes.
        enable = 1'b0;
        rc0 = read_count;
        codec.read_ready = 1'b1;
        codec.readdata_left = 24'h7FFFFF;
        codec.readdata_right = 24'h7FFFFF;
        step();
        step();
        step();
        step();
        codec.read_ready = 1'b0;
        step();
        check("disabled_read_pulses", 64'(read_count - rc0), 64'd0);
        frame(23'h0, 23'h0, 10'h000, 10'h200, 1'b0);
        enable = 1'b1;

        step();
        step();
        step();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
